// File: rtl/key_pkg.sv
// Shared types and constants for the key event reader.
// The KEY_AUTOREPEAT_EN build option is implemented in key_debounce_ch and key_event_reader.
package key_pkg;

    // Key index width in queued events, wide enough for the 16-key maximum.
    localparam int KEY_IDX_W    = 4;
    localparam int DB_LIMIT_MIN = 2;

    typedef struct packed {
        logic [KEY_IDX_W-1:0] key;
        logic                 press;
    } key_evt_t;

endpackage

// File: rtl/key_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce counter, clean level and edge pulses.
// Optional KEY_AUTOREPEAT_EN adds a repeat counter that emits extra press events while held.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int          DB_CNT_W = 24,
    parameter int unsigned DB_LIMIT = 24'h0F4240
`ifdef KEY_AUTOREPEAT_EN
    ,
    parameter int unsigned RPT_DELAY  = 24'h2FAF08,
    parameter int unsigned RPT_PERIOD = 24'h0F4240
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_raw,
    output logic o_key_state,
    output logic o_press_pulse,
    output logic o_release_pulse,
    output logic o_evt_fire,
    output logic o_evt_press
);

    localparam int unsigned DB_LIMIT_EFF =
        (DB_LIMIT < DB_LIMIT_MIN) ? DB_LIMIT_MIN : DB_LIMIT;

    logic                r_sync1;
    logic                r_sync2;
    logic [DB_CNT_W-1:0] r_cnt;
    logic                r_state;
    logic                r_press_pulse;
    logic                r_release_pulse;
    logic                w_differ;
    logic                w_accept;

    assign w_differ = r_sync2 ^ r_state;
    assign w_accept = w_differ && (r_cnt == DB_CNT_W'(DB_LIMIT_EFF - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1         <= 1'b0;
            r_sync2         <= 1'b0;
            r_cnt           <= '0;
            r_state         <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
        end else begin
            r_sync1         <= i_key_raw;
            r_sync2         <= r_sync1;
            r_press_pulse   <= w_accept && !r_state;
            r_release_pulse <= w_accept && r_state;
            // Any return to the accepted level restarts the stability window.
            if (!w_differ || w_accept) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_accept) begin
                r_state <= !r_state;
            end
        end
    end

    assign o_key_state     = r_state;
    assign o_press_pulse   = r_press_pulse;
    assign o_release_pulse = r_release_pulse;

`ifdef KEY_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int          RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] r_rpt_cnt;
    logic             r_rpt_first;
    logic             w_rpt_fire;

    assign w_rpt_fire = r_state && (r_rpt_cnt == (r_rpt_first ? RPT_W'(RPT_DELAY - 1)
                                                                : RPT_W'(RPT_PERIOD - 1)));

    always_ff @(posedge clk) begin
        if (rst || !r_state || w_accept) begin
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b1;
        end else if (w_rpt_fire) begin
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b0;
        end else begin
            r_rpt_cnt <= r_rpt_cnt + 1'b1;
        end
    end

    // An accepted edge takes the slot over a repeat that lands on the same cycle.
    assign o_evt_fire  = w_accept || w_rpt_fire;
    assign o_evt_press = w_accept ? !r_state : 1'b1;
`else
    assign o_evt_fire  = w_accept;
    assign o_evt_press = !r_state;
`endif

endmodule

// File: rtl/key_event_reader.sv
// Debounced push-button reader: per-key level/pulses plus a valid/ready event queue.
// Define KEY_AUTOREPEAT_EN to add auto-repeat press events while a key is held.
module key_event_reader
    import key_pkg::*;
#(
    parameter int          NUM_KEYS   = 5,
    parameter int          DB_CNT_W   = 24,
    parameter int unsigned DB_LIMIT   = 24'h0F4240,
    parameter int          FIFO_DEPTH = 4,
`ifdef KEY_AUTOREPEAT_EN
    parameter int unsigned RPT_DELAY  = 24'h2FAF08,
    parameter int unsigned RPT_PERIOD = 24'h0F4240,
`endif
    localparam int         EVT_KEY_W  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_KEYS-1:0]  key_raw,
    output logic [NUM_KEYS-1:0]  key_state,
    output logic [NUM_KEYS-1:0]  press_pulse,
    output logic [NUM_KEYS-1:0]  release_pulse,
    output logic                 evt_valid,
    output logic [EVT_KEY_W-1:0] evt_key,
    output logic                 evt_press,
    input  logic                 evt_ready,
    output logic                 overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [NUM_KEYS-1:0] w_fire;
    logic [NUM_KEYS-1:0] w_fire_press;

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_ch
        key_debounce_ch #(
            .DB_CNT_W (DB_CNT_W),
            .DB_LIMIT (DB_LIMIT)
`ifdef KEY_AUTOREPEAT_EN
            ,
            .RPT_DELAY (RPT_DELAY),
            .RPT_PERIOD(RPT_PERIOD)
`endif
        ) u_ch (
            .clk            (clk),
            .rst            (rst),
            .i_key_raw      (key_raw[gi]),
            .o_key_state    (key_state[gi]),
            .o_press_pulse  (press_pulse[gi]),
            .o_release_pulse(release_pulse[gi]),
            .o_evt_fire     (w_fire[gi]),
            .o_evt_press    (w_fire_press[gi])
        );
    end

    logic [NUM_KEYS-1:0]  r_pend_v;
    logic [NUM_KEYS-1:0]  r_pend_p;
    logic                 r_overflow;
    key_evt_t             r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W:0]       r_count;

    logic                 w_any;
    logic [KEY_IDX_W-1:0] w_sel;
    logic                 w_sel_press;
    logic [NUM_KEYS-1:0]  w_sel_oh;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic [NUM_KEYS-1:0]  w_grant;
    logic [NUM_KEYS-1:0]  w_drop;
    logic [NUM_KEYS-1:0]  w_set;

    // Fixed priority: scanning downward leaves the lowest valid index selected.
    always_comb begin
        w_any       = 1'b0;
        w_sel       = '0;
        w_sel_press = 1'b0;
        w_sel_oh    = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (r_pend_v[i]) begin
                w_any       = 1'b1;
                w_sel       = KEY_IDX_W'(i);
                w_sel_press = r_pend_p[i];
                w_sel_oh    = NUM_KEYS'(1) << i;
            end
        end
    end

    // Handshake: an entry transfers on any cycle where evt_valid && evt_ready;
    // the head fields hold steady while evt_valid is high and evt_ready is low.
    // Full is judged before the pop, so a same-cycle pop never frees a push slot.
    assign w_full    = (r_count == (PTR_W + 1)'(FIFO_DEPTH));
    assign w_push    = w_any && !w_full;
    assign w_pop     = evt_valid && evt_ready;
    assign w_grant   = w_push ? w_sel_oh : '0;
    assign w_drop    = w_fire & r_pend_v & ~w_grant;
    assign w_set     = w_fire & ~w_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_v   <= '0;
            r_pend_p   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_pend_v   <= (r_pend_v & ~w_grant) | w_set;
            r_pend_p   <= (r_pend_p & ~w_set) | (w_fire_press & w_set);
            r_overflow <= r_overflow | (|w_drop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= '{key: w_sel, press: w_sel_press};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    key_evt_t w_head;
    logic     w_unused_key_hi;

    assign w_head          = r_mem[r_rd_ptr];
    assign w_unused_key_hi = ^w_head.key;
    assign evt_valid       = (r_count != '0);
    assign evt_key         = w_head.key[EVT_KEY_W-1:0];
    assign evt_press       = w_head.press;
    assign overflow        = r_overflow;

endmodule
